// File: rtl/wb_sram_bridge_if.sv
// Purpose : CPU data-port bus bundle (cyc/we/sel/adr/dat/ack/err) between the
//           bexkat1p CPU (master) and the SRAM bridge (slave).
// Ports   : master drives cyc_i/we_i/sel_i/adr_i/dat_i; slave returns dat_o/ack_o/err_o.
interface wb_sram_bridge_if;
   logic        cyc_i;
   logic        we_i;
   logic [3:0]  sel_i;
   logic [31:0] adr_i;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        ack_o;
   logic        err_o;

   modport master (
      output cyc_i, we_i, sel_i, adr_i, dat_i,
      input  dat_o, ack_o, err_o
   );

   modport slave (
      input  cyc_i, we_i, sel_i, adr_i, dat_i,
      output dat_o, ack_o, err_o
   );
endinterface

// File: rtl/wb_sram_bridge.sv
// Purpose : Bus slave that sequences CPU data-port requests into a synchronous
//           single-port block RAM with registered output, returning one ack
//           per transaction with read data held stable alongside it.
// Latency : write acks 2 cycles after the request edge; read acks 2+RD_LAT.
// Backpressure: a request is only accepted in IDLE; the master holds cyc_i
//           until ack_o (dropping cyc_i during a read wait aborts it).
// Ports   : clk_i/rst_i (async, active-high); wb = CPU bus (slave modport);
//           ram_addr/ram_data/ram_wren/ram_byteena drive the RAM, ram_q returns.
// Config  : define WB_BRIDGE_RANGE_ERR_EN to flag accesses with nonzero
//           adr_i[31:AW+2] as errors (err_o) instead of aliasing them.
module wb_sram_bridge #(
   parameter int AW     = 15,
   parameter int RD_LAT = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   wb_sram_bridge_if.slave wb,
   output logic [AW-1:0] ram_addr,
   output logic [31:0]   ram_data,
   output logic          ram_wren,
   output logic [3:0]    ram_byteena,
   input  logic [31:0]   ram_q
);

   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
      $error("wb_sram_bridge: RD_LAT must be in 1..4");
   end

   localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      RWAIT = 3'd2,
      CAPT  = 3'd3,
      ACK   = 3'd4
`ifdef WB_BRIDGE_RANGE_ERR_EN
      , ERR = 3'd5
`endif
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [AW-1:0] r_addr,     w_addr_nxt;
   logic [31:0]   r_wdat,     w_wdat_nxt;
   logic [3:0]    r_be,       w_be_nxt;
   logic [31:0]   r_rdat,     w_rdat_nxt;
   logic [1:0]    r_cnt,      w_cnt_nxt;
   logic          r_wren,     w_wren_nxt;
   logic          r_ack,      w_ack_nxt;
   logic          r_err,      w_err_nxt;

   logic          w_range_err;
   logic          w_accept;

   // Byte-offset bits are never used; upper bits are unused when aliasing.
   logic          w_unused;
   assign w_unused = ^{wb.adr_i[1:0], wb.adr_i[31:AW+2]};

`ifdef WB_BRIDGE_RANGE_ERR_EN
   assign w_range_err = (wb.adr_i >> (AW + 2)) != 32'd0;
`else
   assign w_range_err = 1'b0;
`endif

   // A request that will touch the RAM: latches address/data/lanes.
   assign w_accept = (r_state == IDLE) && wb.cyc_i && !w_range_err;

   // State and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_wdat  <= '0;
         r_be    <= '0;
         r_rdat  <= '0;
         r_cnt   <= '0;
         r_wren  <= 1'b0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_wdat  <= w_wdat_nxt;
         r_be    <= w_be_nxt;
         r_rdat  <= w_rdat_nxt;
         r_cnt   <= w_cnt_nxt;
         r_wren  <= w_wren_nxt;
         r_ack   <= w_ack_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (wb.cyc_i) begin
`ifdef WB_BRIDGE_RANGE_ERR_EN
               if (w_range_err)
                  w_state_nxt = ERR;
               else
`endif
               if (wb.we_i)
                  w_state_nxt = WRITE;
               else
                  w_state_nxt = RWAIT;
            end
         end
         // The write commits regardless of cyc_i, so no abort here.
         WRITE: w_state_nxt = ACK;
         // Abort takes priority over the counter expiring.
         RWAIT: begin
            if (!wb.cyc_i)
               w_state_nxt = IDLE;
            else if (r_cnt == 2'd0)
               w_state_nxt = CAPT;
         end
         CAPT:  w_state_nxt = ACK;
         ACK:   w_state_nxt = IDLE;
`ifdef WB_BRIDGE_RANGE_ERR_EN
         ERR:   w_state_nxt = IDLE;
`endif
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs. Strobes are
   // decoded from the next state so they line up exactly with the state.
   always_comb begin
      w_addr_nxt = r_addr;
      w_wdat_nxt = r_wdat;
      w_be_nxt   = r_be;
      w_rdat_nxt = r_rdat;
      w_cnt_nxt  = r_cnt;
      w_wren_nxt = (w_state_nxt == WRITE);
      w_ack_nxt  = (w_state_nxt == ACK);
`ifdef WB_BRIDGE_RANGE_ERR_EN
      w_err_nxt  = (w_state_nxt == ERR);
`else
      w_err_nxt  = 1'b0;
`endif

      if (w_accept) begin
         w_addr_nxt = wb.adr_i[AW+1:2];
         w_wdat_nxt = wb.dat_i;
         w_be_nxt   = wb.sel_i;
         if (!wb.we_i)
            w_cnt_nxt = LAT_M1;
      end else if (r_state == RWAIT && r_cnt != 2'd0) begin
         w_cnt_nxt = r_cnt - 2'd1;
      end

      // Read data is only replaced by a completed read.
      if (r_state == CAPT)
         w_rdat_nxt = ram_q;
   end

   assign ram_addr    = r_addr;
   assign ram_data    = r_wdat;
   assign ram_wren    = r_wren;
   assign ram_byteena = r_be;
   assign wb.dat_o    = r_rdat;
   assign wb.ack_o    = r_ack;
   assign wb.err_o    = r_err;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Purpose : Directed self-checking bench for wb_sram_bridge (AW=15, RD_LAT=2)
//           with a byte-enabled 2-cycle-latency RAM model.
// Ports   : none; drives the bus interface on falling edges, samples there too.
module tb_wb_sram_bridge;

   logic          clk;
   logic          rst;
   logic [14:0]   ram_addr;
   logic [31:0]   ram_data;
   logic          ram_wren;
   logic [3:0]    ram_byteena;
   logic [31:0]   ram_q;

   int n_cmp;
   int n_bad;

   wb_sram_bridge_if bus ();

   wb_sram_bridge #(.AW(15), .RD_LAT(2)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .wb          (bus),
      .ram_addr    (ram_addr),
      .ram_data    (ram_data),
      .ram_wren    (ram_wren),
      .ram_byteena (ram_byteena),
      .ram_q       (ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: address register then output register -> 2-cycle read latency.
   logic [31:0] mem [0:(1<<15)-1];
   logic [14:0] ram_a_q;
   always @(posedge clk) begin
      if (ram_wren) begin
         for (int b = 0; b < 4; b++)
            if (ram_byteena[b]) mem[ram_addr][8*b +: 8] <= ram_data[8*b +: 8];
      end
      ram_a_q <= ram_addr;
      ram_q   <= mem[ram_a_q];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel);
      bus.cyc_i = 1'b1;
      bus.we_i  = we;
      bus.adr_i = adr;
      bus.dat_i = dat;
      bus.sel_i = sel;
   endtask

   task automatic drop();
      bus.cyc_i = 1'b0;
      bus.we_i  = 1'b0;
   endtask

   // Issued at a falling edge while the bridge is idle; returns at the falling
   // edge of the first idle cycle after the ack.
   task automatic do_write(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [14:0] exp_addr);
      req(1'b1, adr, dat, sel);
      @(negedge clk);
      chk({tag, " wren@N+1"},   32'(ram_wren), 32'd1);
      chk({tag, " addr@N+1"},   32'(ram_addr), 32'(exp_addr));
      chk({tag, " data@N+1"},   ram_data, dat);
      chk({tag, " be@N+1"},     32'(ram_byteena), 32'(sel));
      chk({tag, " ack@N+1"},    32'(bus.ack_o), 32'd0);
      chk({tag, " err@N+1"},    32'(bus.err_o), 32'd0);
      @(negedge clk);
      chk({tag, " ack@N+2"},    32'(bus.ack_o), 32'd1);
      chk({tag, " wren@N+2"},   32'(ram_wren), 32'd0);
      drop();
      @(negedge clk);
      chk({tag, " ack@N+3"},    32'(bus.ack_o), 32'd0);
   endtask

   task automatic do_read(input string tag, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] exp_dat);
      req(1'b0, adr, 32'h0, sel);
      @(negedge clk);
      chk({tag, " addr@N+1"},   32'(ram_addr), 32'(adr[16:2]));
      chk({tag, " be@N+1"},     32'(ram_byteena), 32'(sel));
      chk({tag, " wren@N+1"},   32'(ram_wren), 32'd0);
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         chk({tag, " early ack"}, 32'(bus.ack_o), 32'd0);
      end
      @(negedge clk);
      chk({tag, " ack@N+4"},    32'(bus.ack_o), 32'd1);
      chk({tag, " dat@ack"},    bus.dat_o, exp_dat);
      drop();
      @(negedge clk);
      chk({tag, " ack@N+5"},    32'(bus.ack_o), 32'd0);
      chk({tag, " dat held"},   bus.dat_o, exp_dat);
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      bus.cyc_i = 1'b0;
      bus.we_i  = 1'b0;
      bus.sel_i = 4'h0;
      bus.adr_i = 32'h0;
      bus.dat_i = 32'h0;

      // Reset state
      #2;
      chk("rst ack",   32'(bus.ack_o), 32'd0);
      chk("rst err",   32'(bus.err_o), 32'd0);
      chk("rst wren",  32'(ram_wren), 32'd0);
      chk("rst dat_o", bus.dat_o, 32'h0);
      chk("rst addr",  32'(ram_addr), 32'd0);
      chk("rst data",  ram_data, 32'h0);
      chk("rst be",    32'(ram_byteena), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Full-word write then read back
      do_write("wr10", 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 15'd4);
      do_read ("rd10", 32'h0000_0010, 4'h3, 32'hDEAD_BEEF);

      // Byte-lane write; dat_o must not change on a write
      do_write("wrb1", 32'h0000_0010, 32'h0000_AB00, 4'b0010, 15'd4);
      chk("wr keeps dat_o", bus.dat_o, 32'hDEAD_BEEF);
      do_read ("rdb1", 32'h0000_0010, 4'hF, 32'hDEAD_ABEF);

      // No lanes enabled: full handshake, RAM unchanged
      do_write("wrs0", 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 15'd4);
      do_read ("rds0", 32'h0000_0010, 4'hF, 32'hDEAD_ABEF);

      // Read aborted by dropping cyc_i during the wait
      req(1'b0, 32'h0000_0020, 32'h0, 4'hF);
      @(negedge clk);
      chk("abort ack@N+1", 32'(bus.ack_o), 32'd0);
      @(negedge clk);
      chk("abort ack@N+2", 32'(bus.ack_o), 32'd0);
      drop();
      @(negedge clk);
      chk("abort ack@N+3", 32'(bus.ack_o), 32'd0);
      chk("abort dat_o",   bus.dat_o, 32'hDEAD_ABEF);
      do_write("wrpost", 32'h0000_0020, 32'h1234_5678, 4'hF, 15'd8);
      chk("abort no late ack", 32'(bus.ack_o), 32'd0);
      do_read ("rdpost", 32'h0000_0020, 4'hF, 32'h1234_5678);

      // Out-of-range address
`ifdef WB_BRIDGE_RANGE_ERR_EN
      req(1'b1, 32'h0010_0000, 32'hCAFE_F00D, 4'hF);
      @(negedge clk);
      chk("range err@N+1",  32'(bus.err_o), 32'd1);
      chk("range wren@N+1", 32'(ram_wren), 32'd0);
      chk("range ack@N+1",  32'(bus.ack_o), 32'd0);
      chk("range addr kept", 32'(ram_addr), 32'd8);
      @(negedge clk);
      chk("range err@N+2",  32'(bus.err_o), 32'd0);
      chk("range ack@N+2",  32'(bus.ack_o), 32'd0);
      drop();
      @(negedge clk);
      chk("range dat_o",    bus.dat_o, 32'h1234_5678);
`else
      do_write("alias", 32'h0010_0000, 32'hCAFE_F00D, 4'hF, 15'd0);
      do_read ("rdalias", 32'h0000_0000, 4'hF, 32'hCAFE_F00D);
`endif

      // Reset during a write cycle
      req(1'b1, 32'h0000_0030, 32'h5555_5555, 4'hF);
      @(negedge clk);
      chk("rstmid wren pre", 32'(ram_wren), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstmid wren",  32'(ram_wren), 32'd0);
      chk("rstmid ack",   32'(bus.ack_o), 32'd0);
      chk("rstmid dat_o", bus.dat_o, 32'h0);
      drop();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid no ack", 32'(bus.ack_o), 32'd0);
      chk("rstmid no wr",  32'(ram_wren), 32'd0);
      do_read ("rdrec", 32'h0000_0010, 4'hF, 32'hDEAD_ABEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
